// File: rtl/sha1_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : sha1_bus_master
// Purpose  : Feeds padded 512-bit blocks into the sha1 core register bus,
//            runs init/next, polls status and returns the 160-bit digest.
// Revision : 1.0 - initial release
// ============================================================================
module sha1_bus_master #(
    parameter logic [7:0] ADDR_CTRL    = 8'h08,
    parameter logic [7:0] ADDR_STATUS  = 8'h09,
    parameter logic [7:0] ADDR_BLOCK0  = 8'h10,
    parameter logic [7:0] ADDR_DIGEST0 = 8'h20,
    parameter int         POLL_TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_first,
    input  logic         in_last,
    output logic         dig_valid,
    input  logic         dig_ready,
    output logic [159:0] dig_data,
    output logic         sha_cs,
    output logic         sha_we,
    output logic [7:0]   sha_address,
    output logic [31:0]  sha_write_data,
    input  logic [31:0]  sha_read_data,
    input  logic         sha_error,
    output logic         busy,
    output logic         err
);

    localparam int c_poll_w = $clog2(POLL_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_LOAD = 3'd0,
        S_CTRL = 3'd1,
        S_HOLD = 3'd2,
        S_POLL = 3'd3,
        S_READ = 3'd4,
        S_OUT  = 3'd5
    } state_t;

    state_t              r_state_q,     w_state_d;
    logic [3:0]          r_idx_q,       w_idx_d;
    logic                r_first_q,     w_first_d;
    logic                r_last_q,      w_last_d;
    logic [1:0]          r_hold_q,      w_hold_d;
    logic [c_poll_w-1:0] r_poll_q,      w_poll_d;
    logic [2:0]          r_rd_q,        w_rd_d;
    logic                r_cs_q,        w_cs_d;
    logic                r_we_q,        w_we_d;
    logic [7:0]          r_addr_q,      w_addr_d;
    logic [31:0]         r_wdata_q,     w_wdata_d;
    logic                r_dig_valid_q, w_dig_valid_d;
    logic [159:0]        r_dig_data_q,  w_dig_data_d;
    logic                r_err_q,       w_err_d;
    logic                r_busy_q,      w_busy_d;
    logic [c_poll_w-1:0] w_poll_inc;

    assign w_poll_inc = r_poll_q + c_poll_w'(1);

    always_comb begin
        w_state_d     = r_state_q;
        w_idx_d       = r_idx_q;
        w_first_d     = r_first_q;
        w_last_d      = r_last_q;
        w_hold_d      = r_hold_q;
        w_poll_d      = r_poll_q;
        w_rd_d        = r_rd_q;
        w_cs_d        = 1'b0;
        w_we_d        = 1'b0;
        w_addr_d      = r_addr_q;
        w_wdata_d     = r_wdata_q;
        w_dig_valid_d = r_dig_valid_q;
        w_dig_data_d  = r_dig_data_q;
        w_err_d       = r_err_q;

        // A core error aborts whatever bus activity is in flight; any word
        // offered on this same edge is dropped along with the partial block.
        if (r_cs_q && sha_error) begin
            w_err_d   = 1'b1;
            w_state_d = S_LOAD;
            w_idx_d   = 4'd0;
        end else begin
            case (r_state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        w_cs_d    = 1'b1;
                        w_we_d    = 1'b1;
                        w_addr_d  = ADDR_BLOCK0 + {4'd0, r_idx_q};
                        w_wdata_d = in_data;
                        w_idx_d   = r_idx_q + 4'd1;
                        if (r_idx_q == 4'd0) begin
                            w_first_d = in_first;
                            w_last_d  = in_last;
                        end
                        if (r_idx_q == 4'd15) begin
                            w_state_d = S_CTRL;
                        end
                    end
                end
                S_CTRL: begin
                    w_cs_d    = 1'b1;
                    w_we_d    = 1'b1;
                    w_addr_d  = ADDR_CTRL;
                    w_wdata_d = r_first_q ? 32'h1 : 32'h2;
                    w_hold_d  = 2'd0;
                    w_state_d = S_HOLD;
                end
                S_HOLD: begin
                    // Bus output lags state by one cycle: hold count 0 shows the
                    // CTRL write, counts 1 and 2 are the two idle bus cycles.
                    w_hold_d = r_hold_q + 2'd1;
                    if (r_hold_q == 2'd2) begin
                        w_cs_d    = 1'b1;
                        w_addr_d  = ADDR_STATUS;
                        w_poll_d  = '0;
                        w_state_d = S_POLL;
                    end
                end
                S_POLL: begin
                    if (sha_read_data[0]) begin
                        if (r_last_q) begin
                            w_cs_d    = 1'b1;
                            w_addr_d  = ADDR_DIGEST0;
                            w_rd_d    = 3'd0;
                            w_state_d = S_READ;
                        end else begin
                            w_state_d = S_LOAD;
                        end
                    end else if (w_poll_inc == c_poll_w'(POLL_TIMEOUT)) begin
                        w_err_d   = 1'b1;
                        w_state_d = S_LOAD;
                    end else begin
                        w_poll_d = w_poll_inc;
                        w_cs_d   = 1'b1;
                        w_addr_d = ADDR_STATUS;
                    end
                end
                S_READ: begin
                    // Shift in from the bottom so the first word ends up on top.
                    w_dig_data_d = {r_dig_data_q[127:0], sha_read_data};
                    if (r_rd_q == 3'd4) begin
                        w_dig_valid_d = 1'b1;
                        w_state_d     = S_OUT;
                    end else begin
                        w_rd_d   = r_rd_q + 3'd1;
                        w_cs_d   = 1'b1;
                        w_addr_d = ADDR_DIGEST0 + {5'd0, r_rd_q + 3'd1};
                    end
                end
                S_OUT: begin
                    if (dig_ready) begin
                        w_dig_valid_d = 1'b0;
                        w_state_d     = S_LOAD;
                    end
                end
                default: begin
                    w_state_d = S_LOAD;
                end
            endcase
        end

        w_busy_d = !((w_state_d == S_LOAD) && (w_idx_d == 4'd0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q     <= S_LOAD;
            r_idx_q       <= 4'd0;
            r_first_q     <= 1'b0;
            r_last_q      <= 1'b0;
            r_hold_q      <= 2'd0;
            r_poll_q      <= '0;
            r_rd_q        <= 3'd0;
            r_cs_q        <= 1'b0;
            r_we_q        <= 1'b0;
            r_addr_q      <= 8'd0;
            r_wdata_q     <= 32'd0;
            r_dig_valid_q <= 1'b0;
            r_dig_data_q  <= 160'd0;
            r_err_q       <= 1'b0;
            r_busy_q      <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_idx_q       <= w_idx_d;
            r_first_q     <= w_first_d;
            r_last_q      <= w_last_d;
            r_hold_q      <= w_hold_d;
            r_poll_q      <= w_poll_d;
            r_rd_q        <= w_rd_d;
            r_cs_q        <= w_cs_d;
            r_we_q        <= w_we_d;
            r_addr_q      <= w_addr_d;
            r_wdata_q     <= w_wdata_d;
            r_dig_valid_q <= w_dig_valid_d;
            r_dig_data_q  <= w_dig_data_d;
            r_err_q       <= w_err_d;
            r_busy_q      <= w_busy_d;
        end
    end

    assign in_ready       = (r_state_q == S_LOAD);
    assign sha_cs         = r_cs_q;
    assign sha_we         = r_we_q;
    assign sha_address    = r_addr_q;
    assign sha_write_data = r_wdata_q;
    assign dig_valid      = r_dig_valid_q;
    assign dig_data       = r_dig_data_q;
    assign err            = r_err_q;
    assign busy           = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sha1_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha1_bus_master
// Purpose  : Bench for sha1_bus_master with a behavioural sha1 core model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha1_bus_master;

    localparam logic [159:0] c_iv = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = 32'd0;
    logic         in_first = 1'b0;
    logic         in_last = 1'b0;
    logic         dig_valid;
    logic         dig_ready = 1'b0;
    logic [159:0] dig_data;
    logic         sha_cs;
    logic         sha_we;
    logic [7:0]   sha_address;
    logic [31:0]  sha_write_data;
    logic [31:0]  sha_read_data;
    logic         sha_error;
    logic         busy;
    logic         err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sha1_bus_master dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_first(in_first), .in_last(in_last),
        .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
        .sha_cs(sha_cs), .sha_we(sha_we), .sha_address(sha_address),
        .sha_write_data(sha_write_data), .sha_read_data(sha_read_data),
        .sha_error(sha_error), .busy(busy), .err(err)
    );

    function automatic logic [159:0] sha1_compress(input logic [159:0] h, input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, tmp;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 80; t++) begin
            tmp  = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
            w[t] = {tmp[30:0], tmp[31]};
        end
        {a, b, c, d, e} = h;
        for (int t = 0; t < 80; t++) begin
            if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
            else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
            else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
            else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
            tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
        end
        return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
    endfunction

    // Behavioural sha1 core: block/ctrl/status/digest registers
    logic [511:0] core_blk = '0;
    logic [159:0] core_h = '0;
    logic         core_ready = 1'b1;
    int           core_lat = 0;
    bit           stuck_mode = 1'b0;
    bit           err_mode = 1'b0;

    always @(posedge clk) begin
        if (!core_ready) begin
            if (core_lat <= 1) core_ready <= 1'b1;
            else               core_lat   <= core_lat - 1;
        end
        if (sha_cs && sha_we) begin
            if (sha_address[7:4] == 4'h1)
                core_blk[32*(15-int'(sha_address[3:0])) +: 32] <= sha_write_data;
            else if (sha_address == 8'h08 && sha_write_data[1:0] != 2'b00) begin
                core_h     <= sha1_compress(sha_write_data[0] ? c_iv : core_h, core_blk);
                core_ready <= 1'b0;
                core_lat   <= int'($urandom_range(1, 12));
            end
        end
    end

    always_comb begin
        sha_read_data = 32'd0;
        sha_error     = err_mode && sha_cs && sha_we && (sha_address == 8'h12);
        if (sha_cs) begin
            if (sha_address == 8'h09)
                sha_read_data = {31'd0, core_ready && !stuck_mode};
            else if (sha_address >= 8'h20 && sha_address <= 8'h24)
                sha_read_data = core_h[32*(4-int'(sha_address[2:0])) +: 32];
        end
    end

    // Bus trace monitor, sampled mid-cycle
    typedef struct packed {
        logic [31:0] cyc;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] data;
    } bus_t;

    bus_t        tr[$];
    logic [31:0] cyc = 0;
    logic [31:0] dv_cyc = 0;
    logic        dv_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && sha_cs) tr.push_back('{cyc, sha_we, sha_address, sha_write_data});
        if (dig_valid && !dv_prev) dv_cyc <= cyc;
        dv_prev <= dig_valid;
    end

    function automatic bus_t at(input int p);
        if (p < tr.size()) return tr[p];
        return '{32'hffff_ffff, 1'b0, 8'hff, 32'd0};
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        cycles(2);
        reset = 1'b0;
    endtask

    // gap: 0 back-to-back, 1 every other cycle, 2 random gaps
    task automatic send_block(input logic [511:0] blk, input bit first, input bit last,
                              input int gap, input int nw);
        for (int i = 0; i < nw; i++) begin
            int t = 0;
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = blk[511-32*i -: 32];
            in_first = (i == 0) ? first : 1'($urandom);
            in_last  = (i == 0) ? last  : 1'($urandom);
            while (!in_ready && t < 3000) begin @(negedge clk); t++; end
            if (t >= 3000) chk("in_ready_wait", {159'd0, in_ready}, 160'd1);
            @(posedge clk);
            if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
                @(negedge clk); in_valid = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    logic [511:0] msg_q[$];
    logic [159:0] last_dig;

    task automatic get_digest(input string name, input int stall);
        int t = 0;
        bit stable = 1'b1;
        @(negedge clk);
        while (!dig_valid && t < 5000) begin @(negedge clk); t++; end
        chk({name, "_dig_valid"}, {159'd0, dig_valid}, 160'd1);
        last_dig = dig_data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (dig_valid !== 1'b1 || dig_data !== last_dig || in_ready !== 1'b0) stable = 1'b0;
        end
        if (stall > 0) chk({name, "_stall_stable"}, {159'd0, stable}, 160'd1);
        dig_ready = 1'b1;
        @(negedge clk);
        dig_ready = 1'b0;
        if (stall > 0) chk({name, "_after_handshake"}, {158'd0, in_ready, dig_valid}, 160'd2);
    endtask

    task automatic check_trace(input string name, input bit gapped);
        int p = 0;
        int e = 0;
        int np;
        logic [31:0] lastc = 0;
        logic [31:0] ctrl_c;
        logic [511:0] blk;
        bus_t x;
        for (int b = 0; b < msg_q.size(); b++) begin
            blk = msg_q[b];
            for (int i = 0; i < 16; i++) begin
                x = at(p);
                if (x.we !== 1'b1 || x.addr !== 8'(8'h10 + i) || x.data !== blk[511-32*i -: 32]) e++;
                if (!gapped && i > 0 && x.cyc != lastc + 1) e++;
                lastc = x.cyc; p++;
            end
            x = at(p);
            if (x.we !== 1'b1 || x.addr !== 8'h08 || x.data !== ((b == 0) ? 32'h1 : 32'h2)
                || x.cyc != lastc + 1) e++;
            ctrl_c = x.cyc; p++;
            np = 0;
            while (p < tr.size() && at(p).addr == 8'h09 && at(p).we == 1'b0) begin
                if (np == 0 && at(p).cyc < ctrl_c + 3) e++;
                np++; p++;
            end
            if (np == 0) e++;
            if (b == msg_q.size() - 1) begin
                for (int k = 0; k < 5; k++) begin
                    x = at(p);
                    if (x.we !== 1'b0 || x.addr !== 8'(8'h20 + k) || (k > 0 && x.cyc != lastc + 1)) e++;
                    lastc = x.cyc; p++;
                end
            end
        end
        if (p != tr.size()) e++;
        if (dv_cyc != lastc + 1) e++;
        chk({name, "_trace"}, 160'(e), 160'd0);
    endtask

    task automatic run_msg(input string name, input int gap, input int stall);
        logic [159:0] h = c_iv;
        tr.delete();
        for (int b = 0; b < msg_q.size(); b++) begin
            send_block(msg_q[b], b == 0, b == msg_q.size() - 1, gap, 16);
            h = sha1_compress(h, msg_q[b]);
        end
        get_digest(name, stall);
        chk({name, "_digest"}, last_dig, h);
        check_trace(name, gap != 0);
    endtask

    logic [511:0] abc_blk, tb_blk1, tb_blk2, rnd_blk;
    int n;

    initial begin
        abc_blk = {32'h61626380, 448'd0, 32'h00000018};
        tb_blk1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        tb_blk2 = {480'd0, 32'h000001c0};

        cycles(3);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {sha_cs, sha_we, sha_address, sha_write_data, dig_valid, err, busy},
            160'd0);
        chk("reset_dig_data", dig_data, 160'd0);
        chk("reset_in_ready", {159'd0, in_ready}, 160'd1);

        msg_q = {abc_blk};
        run_msg("abc", 0, 0);
        chk("abc_known", last_dig, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);
        chk("abc_err", {159'd0, err}, 160'd0);

        msg_q = {tb_blk1, tb_blk2};
        run_msg("two_block", 0, 0);
        chk("two_block_known", last_dig, 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1);

        msg_q = {tb_blk1, tb_blk2};
        run_msg("gapped", 1, 0);

        for (int r = 0; r < 4; r++) begin
            msg_q.delete();
            for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
                for (int i = 0; i < 16; i++) rnd_blk[511-32*i -: 32] = $urandom;
                msg_q.push_back(rnd_blk);
            end
            run_msg($sformatf("rand%0d", r), int'($urandom_range(0, 2)), 0);
        end
        chk("rand_err", {159'd0, err}, 160'd0);

        msg_q = {abc_blk};
        run_msg("stall", 0, 50);

        tr.delete();
        send_block(abc_blk, 1'b1, 1'b1, 0, 8);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", {sha_cs, sha_we, sha_address, sha_write_data, dig_valid, err, busy},
            160'd0);
        chk("midreset_in_ready", {159'd0, in_ready}, 160'd1);
        reset = 1'b0;
        msg_q = {abc_blk};
        run_msg("abc_after_reset", 0, 0);

        err_mode = 1'b1;
        tr.delete();
        send_block(abc_blk, 1'b1, 1'b1, 0, 4);
        chk("core_err_state", {156'd0, err, sha_cs, busy, in_ready}, 160'b1001);
        err_mode = 1'b0;
        cycles(10);
        chk("core_err_writes", 160'(tr.size()), 160'd3);
        msg_q = {abc_blk};
        run_msg("abc_after_err", 0, 0);
        chk("err_sticky", {159'd0, err}, 160'd1);

        pulse_reset();
        chk("reset_clears_err", {159'd0, err}, 160'd0);
        stuck_mode = 1'b1;
        tr.delete();
        send_block(abc_blk, 1'b1, 1'b1, 0, 16);
        n = 0;
        while (!err && n < 1500) begin @(negedge clk); n++; end
        chk("timeout_state", {157'd0, err, sha_cs, in_ready}, 160'b101);
        n = 0;
        foreach (tr[i]) if (tr[i].addr == 8'h09 && !tr[i].we) n++;
        chk("timeout_polls", 160'(n), 160'd1024);
        stuck_mode = 1'b0;
        msg_q = {abc_blk};
        run_msg("abc_after_timeout", 0, 0);
        chk("timeout_err_sticky", {159'd0, err}, 160'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sha1_bus_master.md
# sha1_bus_master

Hardware initiator for the sha1 core's register bus: it takes the place of the Nios PIO software path that drives address/write/read/cs/we. It accepts a message as a stream of 32-bit words (16 per 512-bit block, already padded), writes each block into the core, issues init/next, polls status, and after the last block reads the 160-bit digest and presents it on a valid/ready output.

## Interface
Parameters:
- ADDR_CTRL, 8'h08, core control register (bit0 init, bit1 next)
- ADDR_STATUS, 8'h09, core status register (bit0 ready)
- ADDR_BLOCK0, 8'h10, first of 16 block-word registers (0x10..0x1F)
- ADDR_DIGEST0, 8'h20, first of 5 digest registers (0x20..0x24)
- POLL_TIMEOUT, 1024, maximum status polls per block before error

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts a word this cycle
- in_data  in  32  message word, big-endian within the block
- in_first  in  1  first block of the message; sampled with word 0 only
- in_last  in  1  last block of the message; sampled with word 0 only
- dig_valid  out  1  digest available
- dig_ready  in  1  consumer takes digest
- dig_data  out  160  digest; word at ADDR_DIGEST0 in [159:128]
- sha_cs  out  1  core chip select
- sha_we  out  1  core write enable
- sha_address  out  8  core register address
- sha_write_data  out  32  core write data
- sha_read_data  in  32  core read data, combinational from sha_address while sha_cs=1
- sha_error  in  1  core error flag
- busy  out  1  high in every state except LOAD with word index 0
- err  out  1  sticky error, cleared only by reset

## Operation
- States: LOAD, CTRL, HOLD, POLL, READ, OUT.
- LOAD: in_ready=1. Each accepted word is registered and produces one write on the next cycle: cs=1, we=1, address=ADDR_BLOCK0+idx, write_data=word. idx is 4 bits and increments per accepted word. Acceptance of word 15 moves the FSM to CTRL.
- CTRL: one write to ADDR_CTRL with data 32'h1 when the block's in_first is set, otherwise 32'h2. Then HOLD.
- HOLD: 2 idle cycles with cs=0, so the core has cleared ready before the first poll. Then POLL.
- POLL: cs=1, we=0, address=ADDR_STATUS every cycle. sha_read_data[0] is sampled at the end of the same cycle.
  - ready=1 and the block is not last: go to LOAD with idx=0.
  - ready=1 and the block is last: go to READ.
  - The poll counter resets on entry to POLL. When the count reaches POLL_TIMEOUT without ready, set err and go to LOAD.
- READ: 5 consecutive read cycles at ADDR_DIGEST0+0..4. Each word is captured into dig_data at the end of its cycle. Then OUT.
- OUT: dig_valid=1, and dig_data is held stable until dig_valid&dig_ready. Then go to LOAD.
- sha_error sampled high during any cycle with cs=1: set err, drop cs next cycle, go to LOAD with idx=0. The partial block is discarded.
- A non-first block before any first block is still sent with next (32'h2). Sequencing is the producer's responsibility.
- Whenever cs=0, sha_we=0 and sha_address and sha_write_data hold their last values.

## Timing
- Reset values: sha_cs=0, sha_we=0, sha_address=0, sha_write_data=0, dig_valid=0, dig_data=0, err=0, busy=0. State=LOAD, idx=0, in_ready=1 in the first cycle after reset.
- in_ready is a combinational decode of state (LOAD).
- All sha_* outputs, dig_*, err and busy are registered.
- A word accepted at edge N is written to the core in cycle N+1.
- With in_valid held high, the 16 writes occupy 16 consecutive cycles. The CTRL write immediately follows the last block write.
- Minimum block overhead after the last block write: 1 CTRL + 2 HOLD + polls.
- Minimum path from the final ready poll to dig_valid: 5 read cycles, then dig_valid in the next cycle.
- Reset mid-operation: sha_cs falls at the first edge where reset=1. The in-flight block and digest are lost. The core is not reset by this block, so the next message must start with in_first=1.

## Test plan
- Single block "abc" (0x61626380, 13×0, 0x00000000, 0x00000018), first=last=1, against the sha1 core. Required: CTRL written with 0x1, dig_data = a9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d, err=0.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (standard padding). Required: CTRL 0x1 then 0x2, and dig_data = 84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1.
- Bus trace check with in_valid gapped every other cycle:
  - writes go to addresses 0x10..0x1F in order with the accepted data;
  - no POLL occurs within 2 cycles of the CTRL write;
  - digest reads go to 0x20..0x24.
- Stub core holding status=0: exactly 1024 STATUS reads, then err=1, cs=0, in_ready=1. err stays 1 until reset.
- dig_ready held low for 50 cycles: dig_valid and dig_data stay stable and in_ready=0. dig_ready=1 for one cycle returns the FSM to LOAD.
- Reset asserted after word 7 of a block: next cycle sha_cs=0, all outputs at reset values. The "abc" test repeated afterwards passes.
- Stub core raising sha_error on the 3rd block write: err=1, no CTRL write follows, and idx restarts at 0.
